// File: rtl/dense_layer_mac.sv
// Streams one x[j] plus a weight column per accepted beat into rows parallel MACs, then adds bias, floors, saturates.
// Result lands 1 cycle after the last beat (FINAL); in_ready is high only in ACCUM, so upstream stalls in all other states.
module dense_layer_mac #(
  parameter int datawidth = 11,
  parameter int rows      = 4,
  parameter int cols      = 4,
  parameter int frac      = 5
) (
  input  logic                        clk,
  input  logic                        rst_overall,
  input  logic                        rst_vals,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [datawidth-1:0] x_in,
  input  logic [rows*datawidth-1:0]   w_col,
  input  logic [rows*datawidth-1:0]   bias,
  output logic [rows*datawidth-1:0]   out,
  output logic                        layer_done
);

  localparam int accw = 2*datawidth + $clog2(cols) + 1;
  // Headroom for acc + shifted bias without wrap.
  localparam int sumw = ((accw > datawidth + frac) ? accw : datawidth + frac) + 1;
  localparam int cntw = (cols > 1) ? $clog2(cols) : 1;
  localparam logic [cntw-1:0] last_beat = cntw'(cols - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [cntw-1:0]        cnt;
  logic signed [accw-1:0] acc  [rows];
  logic signed [accw-1:0] prod [rows];
  logic [rows*datawidth-1:0] sat_bus;

  assign in_ready   = (state == ACCUM);
  assign layer_done = (state == DONE);

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rst_vals) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = ACCUM;
        ACCUM:   if (in_valid && cnt == last_beat) state_nxt = FINAL;
        FINAL:   state_nxt = DONE;
        DONE:    if (start) state_nxt = ACCUM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin : lane_math
    logic signed [datawidth-1:0]   w;
    logic signed [2*datawidth-1:0] p;
    logic signed [datawidth-1:0]   b;
    logic signed [sumw-1:0]        s;
    logic signed [sumw-1:0]        y;
    w = '0;
    p = '0;
    b = '0;
    s = '0;
    y = '0;
    sat_bus = '0;
    for (int r = 0; r < rows; r++) begin
      w       = w_col[r*datawidth +: datawidth];
      p       = x_in * w;
      prod[r] = {{(accw-2*datawidth){p[2*datawidth-1]}}, p};
      b       = bias[r*datawidth +: datawidth];
      s = {{(sumw-accw){acc[r][accw-1]}}, acc[r]}
        + ({{(sumw-datawidth){b[datawidth-1]}}, b} <<< frac);
      y = s >>> frac;
      // In range only when every bit above the output sign matches it.
      if (&y[sumw-1:datawidth-1] || ~|y[sumw-1:datawidth-1])
        sat_bus[r*datawidth +: datawidth] = y[datawidth-1:0];
      else if (y[sumw-1])
        sat_bus[r*datawidth +: datawidth] = {1'b1, {(datawidth-1){1'b0}}};
      else
        sat_bus[r*datawidth +: datawidth] = {1'b0, {(datawidth-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      cnt <= '0;
      out <= '0;
      for (int r = 0; r < rows; r++) acc[r] <= '0;
    end else if (rst_vals) begin
      cnt <= '0;
      out <= '0;
      for (int r = 0; r < rows; r++) acc[r] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
            for (int r = 0; r < rows; r++) acc[r] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int r = 0; r < rows; r++) acc[r] <= acc[r] + prod[r];
            cnt <= (cnt == last_beat) ? '0 : cnt + 1'b1;
          end
        end
        FINAL:   out <= sat_bus;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Bench for dense_layer_mac: directed table vectors, hand-written reset/backpressure sequences, random passes vs. an arithmetic model.
module tb_dense_layer_mac;

  localparam int DW   = 11;
  localparam int R    = 4;
  localparam int C    = 3;
  localparam int F    = 5;
  localparam int MAXV = (1 << (DW-1)) - 1;
  localparam int MINV = -(1 << (DW-1));

  typedef struct packed {
    logic [C-1:0][31:0]        x;
    logic [C-1:0][R-1:0][31:0] w;
    logic [R-1:0][31:0]        b;
    logic [R-1:0][31:0]        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_overall = 1'b1;
  logic rst_vals = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic layer_done;
  logic [DW-1:0]   x_in = '0;
  logic [R*DW-1:0] w_col = '0;
  logic [R*DW-1:0] bias = '0;
  logic [R*DW-1:0] out;

  int nvec;
  int nerr;

  dense_layer_mac #(.datawidth(DW), .rows(R), .cols(C), .frac(F)) dut (
    .clk(clk), .rst_overall(rst_overall), .rst_vals(rst_vals), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_col(w_col),
    .bias(bias), .out(out), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int xv, input int w0, input int w1, input int w2, input int w3,
                              input int b0, input int b1, input int b2, input int b3,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v = '0;
    for (int j = 0; j < C; j++) begin
      v.x[j]    = xv;
      v.w[j][0] = w0; v.w[j][1] = w1; v.w[j][2] = w2; v.w[j][3] = w3;
    end
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  // Reference: exact dot product, bias scaled to the product's Q format, floor, clamp.
  function automatic int model_lane(input vec_t v, input int r);
    longint s;
    s = 0;
    for (int j = 0; j < C; j++)
      s += longint'($signed(v.x[j])) * longint'($signed(v.w[j][r]));
    s += longint'($signed(v.b[r])) * (longint'(1) << F);
    s = s >>> F;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    return int'(s);
  endfunction

  task automatic drive_beat(input vec_t v, input int j);
    x_in = v.x[j][DW-1:0];
    for (int r = 0; r < R; r++) w_col[r*DW +: DW] = v.w[j][r][DW-1:0];
  endtask

  task automatic drive_garbage();
    x_in  = DW'($urandom());
    w_col = (R*DW)'({$urandom(), $urandom()});
  endtask

  task automatic check_out_zero(input string tag);
    check({tag, "_out_zero"}, int'(out == '0), 1);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_layer_done"}, int'(layer_done), 0);
  endtask

  // mode 0: valid every cycle, 1: random gaps, 2: fixed pattern 1,0,0,1,0,1
  task automatic run_pass(input vec_t v, input int mode, input string tag);
    logic [R*DW-1:0] prev;
    bit [5:0] bp;
    int j;
    int k;
    bp = 6'b101001;
    prev = out;
    for (int r = 0; r < R; r++) bias[r*DW +: DW] = v.b[r][DW-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_rdy_after_start"}, int'(in_ready), 1);
    check({tag, "_done_low_in_accum"}, int'(layer_done), 0);
    j = 0;
    k = 0;
    while (j < C) begin
      if (k >= 40) begin
        check({tag, "_beat_budget"}, k, 0);
        break;
      end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = bp[k % 6];
      endcase
      if (in_valid) drive_beat(v, j);
      else          drive_garbage();
      @(posedge clk); #1;
      if (in_valid) j++;
      k++;
    end
    in_valid = 1'b1;
    drive_garbage();
    check({tag, "_final_rdy"}, int'(in_ready), 0);
    check({tag, "_final_done"}, int'(layer_done), 0);
    check({tag, "_out_held"}, int'(out == prev), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_layer_done"}, int'(layer_done), 1);
    check({tag, "_done_rdy"}, int'(in_ready), 0);
    for (int r = 0; r < R; r++)
      check($sformatf("%s_lane%0d", tag, r), int'($signed(out[r*DW +: DW])), int'($signed(v.e[r])));
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    nvec = 0;
    nerr = 0;

    tbl[0] = mk(32, 32, -32, 0, 16, 0, 0, 0, 0, 96, -96, 0, 48);
    tbl[1] = mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0);
    tbl[1].x[0] = 1;
    tbl[1].w[0][0] = -1;
    tbl[2] = tbl[1];
    tbl[2].b[0] = 0;
    tbl[2].e[0] = -1;
    tbl[3] = mk(1023, 1023, 1023, 1023, 1023, 0, 0, 0, 0, 1023, 1023, 1023, 1023);
    tbl[4] = mk(1023, -1024, -1024, -1024, -1024, 0, 0, 0, 0, -1024, -1024, -1024, -1024);
    tbl[5] = mk(0, 5, 5, 5, 5, -3, 5, -1024, 1023, -3, 5, -1024, 1023);

    repeat (3) @(posedge clk);
    #1;
    check_out_zero("reset");
    rst_overall = 1'b0;

    in_valid = 1'b1;
    drive_garbage();
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_ignores_valid", int'(in_ready), 0);

    for (int i = 0; i < 6; i++) run_pass(tbl[i], 0, $sformatf("tbl%0d", i));

    run_pass(tbl[0], 2, "backpressure");
    run_pass(tbl[3], 1, "sat_gaps");

    // rst_vals in DONE beats a simultaneous start
    rst_vals = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst_vals = 1'b0;
    start = 1'b0;
    check_out_zero("rstv_done");
    run_pass(tbl[5], 0, "after_rstv_done");

    // rst_vals mid-ACCUM, arriving with what would be the third beat
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      drive_beat(tbl[0], j);
      @(posedge clk); #1;
    end
    drive_beat(tbl[0], 2);
    rst_vals = 1'b1;
    @(posedge clk); #1;
    rst_vals = 1'b0;
    check_out_zero("rstv_accum");
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstv_accum_no_result", int'(layer_done), 0);
    run_pass(tbl[0], 0, "after_rstv_accum");

    // start in DONE keeps the old result; async rst_overall mid-beat clears at once
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_done_drop", int'(layer_done), 0);
    check("restart_out_kept", int'($signed(out[DW-1:0])), 96);
    in_valid = 1'b1;
    drive_beat(tbl[0], 0);
    @(posedge clk); #3;
    rst_overall = 1'b1;
    #1;
    check_out_zero("arst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_overall = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("arst_no_result", int'(layer_done), 0);
    check("arst_idle", int'(in_ready), 0);

    for (int i = 0; i < 40; i++) begin
      v = '0;
      for (int j = 0; j < C; j++) begin
        if (i % 2 == 0) v.x[j] = int'($urandom_range(0, 2047)) - 1024;
        else            v.x[j] = int'($urandom_range(0, 127)) - 64;
        for (int r = 0; r < R; r++) begin
          if (i % 2 == 0) v.w[j][r] = int'($urandom_range(0, 2047)) - 1024;
          else            v.w[j][r] = int'($urandom_range(0, 127)) - 64;
        end
      end
      for (int r = 0; r < R; r++) v.b[r] = int'($urandom_range(0, 2047)) - 1024;
      for (int r = 0; r < R; r++) v.e[r] = model_lane(v, r);
      run_pass(v, 1, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
